ap_window_feeder: RTL and testbench
===================================

# ap_window_feeder

Frame-buffered sliding-window generator that feeds the AP convolution array. It accepts a feature map as a raster pixel stream and stores it internally. It then emits one packed K×K window per cycle on the AP `in` port format, with `win_en` driving AP `en`. In pool mode, windows come out in 2×2 max-pool quad order, so the AP's `en_mp` path sees four consecutive windows per pooled output. Runtime map size, parametrised kernel size and zero-padding of unused cells replace hand-sequenced window feeding.

## Interface
- `CELL_BIT`, 8, bits per pixel
- `N_CELL`, 9, cells per AP input word; K*K <= N_CELL
- `K`, 3, kernel side
- `MAX_W`, 28, maximum map width
- `MAX_H`, 28, maximum map height
- `DIM_BIT`, 5, width of size config fields
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle job start; config sampled same edge
- `cfg_w`  in  DIM_BIT  map width
- `cfg_h`  in  DIM_BIT  map height
- `cfg_pool`  in  1  1 = 2×2 quad ordering
- `in_pixel`  in  CELL_BIT  input pixel
- `in_valid`  in  1  pixel valid
- `in_ready`  out  1  block accepts pixel
- `win`  out  CELL_BIT*N_CELL  packed window
- `win_en`  out  1  window valid (to AP `en`)
- `busy`  out  1  job in FILL or SCAN
- `done`  out  1  one-cycle end-of-job pulse
- `err`  out  1  one-cycle bad-config pulse

## Operation
- States: IDLE, FILL, SCAN.
- Reset puts the block in IDLE. All outputs read 0.
- IDLE → FILL on `start` when K <= cfg_w <= MAX_W and K <= cfg_h <= MAX_H.
  - The config is latched on that edge.
- If the config is invalid, `err` =1 for one cycle and the block stays in IDLE.
- `start` is ignored outside IDLE.
- FILL: `in_ready`=1.
  - A pixel is accepted on an edge where `in_valid`&`in_ready`.
  - Pixels are stored row-major, for cfg_w*cfg_h pixels in total.
  - `in_valid` gaps are allowed.
  - On the edge that accepts the last pixel, the state goes to SCAN and `in_ready`=0.
- Output dimensions:
  - OW = cfg_w−K+1, OH = cfg_h−K+1.
  - Pool mode: PW = floor(OW/2), PH = floor(OH/2). The odd last row and column are dropped.
- SCAN emission order:
  - pool=0: window origins (r,c) in raster order, r<OH, c<OW.
  - pool=1: for each (pr,pc) in raster order, emit origins (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
  - If PW or PH is 0, no windows are emitted and `done` still fires.
- Window packing:
  - Kernel element (a,b) = pixel[r+a][c+b].
  - It occupies `win[CELL_BIT*N_CELL-1-CELL_BIT*(a*K+b) -: CELL_BIT]`, MSB-first.
  - Cell slots K*K..N_CELL−1 are 0.
- Pixel data passes through unmodified; no sign or shift processing.
- Storage is a MAX_W*MAX_H register array. K*K combinational reads per cycle.

## Timing
- `win` and `win_en` are registered.
- Let E be the edge accepting the last pixel. The first window is valid from edge E+1.
- Windows then follow back-to-back, one per cycle, with no stalls. There is no backpressure.
- `win` holds its last value while `win_en`=0. It reads 0 after reset.
- `done` =1 in the cycle right after the last `win_en` cycle, then the block returns to IDLE.
  - `busy` =0 in the `done` cycle.
- `busy` =1 from the edge after an accepted `start` until the `done` cycle.
- A `start` arriving in the `done` cycle is accepted (the block is in IDLE then).
- `reset` has priority over everything.
  - Mid-FILL or mid-SCAN, it forces IDLE at the next edge.
  - `win_en`, `in_ready`, `busy`, `done` and `err` are all 0 after that edge.
  - No `done` pulse is generated.
- Latency from start to the first window is cfg_w*cfg_h+1 cycles minimum, with no `in_valid` gaps.

## Test plan
1. K=3, w=h=4, pool=0, pixels 0..15 gap-free.
   - 4 windows on consecutive cycles.
   - win0={0,1,2,4,5,6,8,9,10}; win3={5,6,7,9,10,11,13,14,15}.
   - `done` in the next cycle.
2. w=h=6, pool=1, pixels 0..35 → 16 windows.
   - Origins of windows 0–3: (0,0),(0,1),(1,0),(1,1).
   - Window 4 origin (0,2): first cells {2,3,4}.
3. w=h=5, pool=1 (OW=3, PW=1).
   - Exactly 4 windows, origins (0,0),(0,1),(1,0),(1,1).
   - Origin (2,*) is never emitted.
4. Scenario 1 with `in_valid` toggling every cycle.
   - FILL takes 32 cycles; windows are identical to scenario 1.
   - `start` pulsed during SCAN is ignored.
5. cfg_w=2, and separately cfg_h=29.
   - `err` high for one cycle; `in_ready`/`busy` stay 0.
   - A following valid `start` runs normally.
6. K=2 build (N_CELL=9), w=h=3, pixels 1..9, pool=0.
   - win0={1,2,4,5,0,0,0,0,0}.
   - Assert `reset` after the 2nd window: next edge `win_en`=0, `busy`=0, no `done`.

Source files
------------

// File: rtl/ap_window_feeder.sv
`timescale 1ns/1ps
// Frame-buffered sliding-window generator: stores a raster feature map, then streams one
// packed KxK window per cycle to the AP array in raster or 2x2 max-pool quad order.
module ap_window_feeder #(
    parameter int CELL_BIT = 8,
    parameter int N_CELL   = 9,
    parameter int K        = 3,
    parameter int MAX_W    = 28,
    parameter int MAX_H    = 28,
    parameter int DIM_BIT  = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DIM_BIT-1:0]           cfg_w,
    input  logic [DIM_BIT-1:0]           cfg_h,
    input  logic                         cfg_pool,
    input  logic [CELL_BIT-1:0]          in_pixel,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CELL_BIT*N_CELL-1:0]   win,
    output logic                         win_en,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int DEPTH = MAX_W * MAX_H;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int WIN_W = CELL_BIT * N_CELL;

    typedef enum logic [1:0] {IDLE, FILL, SCAN} state_t;
    state_t state, state_nxt;

    logic [CELL_BIT-1:0] mem [DEPTH];
    logic [DIM_BIT-1:0]  w_q, h_q;
    logic                pool_q;
    logic [AW-1:0]       pix_cnt, pix_total;
    logic [DIM_BIT-1:0]  ow, oh, row_lim, col_lim, row_q, col_q;
    logic [1:0]          quad_q;
    logic                scan_end, scan_empty, cfg_ok, pix_last;
    logic                at_last_pos, step_pos, win_last;
    logic [DIM_BIT:0]    org_r, org_c;
    logic [WIN_W-1:0]    win_p0;

    assign cfg_ok = (int'(cfg_w) >= K) && (int'(cfg_w) <= MAX_W) &&
                    (int'(cfg_h) >= K) && (int'(cfg_h) <= MAX_H);

    assign ow         = w_q - DIM_BIT'(K - 1);
    assign oh         = h_q - DIM_BIT'(K - 1);
    // In pool mode the counters walk pooled outputs; odd trailing row/column is dropped.
    assign row_lim    = pool_q ? (oh >> 1) : oh;
    assign col_lim    = pool_q ? (ow >> 1) : ow;
    assign scan_empty = (row_lim == '0) || (col_lim == '0);
    assign pix_total  = AW'(w_q) * AW'(h_q);
    assign pix_last   = (pix_cnt == pix_total - AW'(1));

    assign at_last_pos = (row_q == row_lim - DIM_BIT'(1)) && (col_q == col_lim - DIM_BIT'(1));
    assign step_pos    = !pool_q || (quad_q == 2'd3);
    assign win_last    = at_last_pos && step_pos;
    // Quad member q places the origin at (2*pr + q[1], 2*pc + q[0]).
    assign org_r = pool_q ? {row_q, quad_q[1]} : {1'b0, row_q};
    assign org_c = pool_q ? {col_q, quad_q[0]} : {1'b0, col_q};

    // Stage p0: combinational gather of the KxK window at the current origin
    always_comb begin
        win_p0 = '0;
        for (int a = 0; a < K; a++) begin
            for (int b = 0; b < K; b++) begin
                win_p0[WIN_W-1-CELL_BIT*(a*K+b) -: CELL_BIT] =
                    mem[(AW'(org_r) + AW'(a)) * AW'(w_q) + AW'(org_c) + AW'(b)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_ok) state_nxt = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && pix_last) state_nxt = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (scan_end || scan_empty) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == FILL && in_valid) mem[pix_cnt] <= in_pixel;
    end

    // Stage p1: registered window output and job control
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q      <= '0;
            h_q      <= '0;
            pool_q   <= 1'b0;
            pix_cnt  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            quad_q   <= '0;
            scan_end <= 1'b0;
            win      <= '0;
            win_en   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            win_en <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w_q      <= cfg_w;
                            h_q      <= cfg_h;
                            pool_q   <= cfg_pool;
                            pix_cnt  <= '0;
                            row_q    <= '0;
                            col_q    <= '0;
                            quad_q   <= '0;
                            scan_end <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) pix_cnt <= pix_cnt + AW'(1);
                end
                SCAN: begin
                    if (scan_end || scan_empty) begin
                        done <= 1'b1;
                    end else begin
                        win      <= win_p0;
                        win_en   <= 1'b1;
                        scan_end <= win_last;
                        if (pool_q) quad_q <= quad_q + 2'd1;
                        if (step_pos) begin
                            if (col_q == col_lim - DIM_BIT'(1)) begin
                                col_q <= '0;
                                row_q <= row_q + DIM_BIT'(1);
                            end else begin
                                col_q <= col_q + DIM_BIT'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ap_window_feeder.sv
`timescale 1ns/1ps
// Directed bench for ap_window_feeder: a table of map jobs with hand-computed windows,
// plus sequences for bad config, a K=2 build and reset during SCAN.
module tb_ap_window_feeder;
    localparam int WIN_W = 72;

    logic             clk = 1'b0;
    logic             reset, start, cfg_pool, in_valid;
    logic [4:0]       cfg_w, cfg_h;
    logic [7:0]       in_pixel;
    logic             in_ready, win_en, busy, done, err;
    logic [WIN_W-1:0] win;
    logic             in_ready2, win_en2, busy2, done2, err2;
    logic [WIN_W-1:0] win2;

    int n_chk  = 0;
    int n_fail = 0;
    logic [WIN_W-1:0] wq[$];

    typedef struct {
        int         w;
        int         h;
        bit         pool;
        bit         gap;
        bit         poke;
        int         exp_n;
        int         exp_fill;
        int         i0;
        int         i1;
        int         i2;
        logic [WIN_W-1:0] e0;
        logic [WIN_W-1:0] e1;
        logic [WIN_W-1:0] e2;
    } job_t;

    job_t jobs[4];

    always #5 clk = ~clk;

    ap_window_feeder #(.CELL_BIT(8), .N_CELL(9), .K(3), .MAX_W(28), .MAX_H(28), .DIM_BIT(5)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_pool(cfg_pool), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .win(win), .win_en(win_en), .busy(busy), .done(done), .err(err)
    );

    ap_window_feeder #(.CELL_BIT(8), .N_CELL(9), .K(2), .MAX_W(28), .MAX_H(28), .DIM_BIT(5)) dut_k2 (
        .clk(clk), .reset(reset), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_pool(cfg_pool), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready2),
        .win(win2), .win_en(win_en2), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] win_at(input int idx);
        if (idx < wq.size()) return wq[idx];
        return '1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds n pixels base, base+1, ...; with gap, in_valid is low on even cycles.
    task automatic feed(input int n, input int base, input bit gap, output int fill_cyc);
        int  i = 0;
        int  t = 0;
        bit  acc;
        fill_cyc = 0;
        while (i < n && t < 4000) begin
            in_valid = gap ? (t % 2 == 1) : 1'b1;
            in_pixel = 8'(base + i);
            if (in_ready) fill_cyc++;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (i < n) begin
            n_chk++;
            n_fail++;
            $display("FAIL feed_timeout: got %0d pixels, expected %0d", i, n);
        end
    endtask

    task automatic run_job(input job_t j, input int id);
        int fill_cyc;
        int t;
        cfg_w    = 5'(j.w);
        cfg_h    = 5'(j.h);
        cfg_pool = j.pool;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk1($sformatf("job%0d_busy_fill", id), busy, 1'b1);
        feed(j.w * j.h, 0, j.gap, fill_cyc);
        chki($sformatf("job%0d_fill_cycles", id), fill_cyc, j.exp_fill);
        chk1($sformatf("job%0d_ready_low_after_fill", id), in_ready, 1'b0);
        chk1($sformatf("job%0d_no_win_at_E", id), win_en, 1'b0);
        tick();
        chk1($sformatf("job%0d_first_win_at_E1", id), win_en, 1'b1);
        wq.delete();
        t = 0;
        while (win_en && t < 200) begin
            wq.push_back(win);
            start = j.poke && (t == 0);
            tick();
            t++;
        end
        start = 1'b0;
        chki($sformatf("job%0d_num_windows", id), wq.size(), j.exp_n);
        chk1($sformatf("job%0d_done_after_last", id), done, 1'b1);
        chk1($sformatf("job%0d_busy_low_in_done", id), busy, 1'b0);
        chkw($sformatf("job%0d_win_hold", id), win, win_at(wq.size() - 1));
        chkw($sformatf("job%0d_win%0d", id, j.i0), win_at(j.i0), j.e0);
        chkw($sformatf("job%0d_win%0d", id, j.i1), win_at(j.i1), j.e1);
        chkw($sformatf("job%0d_win%0d", id, j.i2), win_at(j.i2), j.e2);
        tick();
        chk1($sformatf("job%0d_done_one_cycle", id), done, 1'b0);
        chk1($sformatf("job%0d_idle_after_done", id), busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fc;
        jobs[0] = '{4, 4, 1'b0, 1'b0, 1'b0, 4, 16, 0, 1, 3,
                    72'h00_01_02_04_05_06_08_09_0A,
                    72'h01_02_03_05_06_07_09_0A_0B,
                    72'h05_06_07_09_0A_0B_0D_0E_0F};
        jobs[1] = '{6, 6, 1'b1, 1'b0, 1'b0, 16, 36, 2, 4, 15,
                    72'h06_07_08_0C_0D_0E_12_13_14,
                    72'h02_03_04_08_09_0A_0E_0F_10,
                    72'h15_16_17_1B_1C_1D_21_22_23};
        jobs[2] = '{5, 5, 1'b1, 1'b0, 1'b0, 4, 25, 0, 1, 3,
                    72'h00_01_02_05_06_07_0A_0B_0C,
                    72'h01_02_03_06_07_08_0B_0C_0D,
                    72'h06_07_08_0B_0C_0D_10_11_12};
        jobs[3] = '{4, 4, 1'b0, 1'b1, 1'b1, 4, 32, 0, 1, 3,
                    72'h00_01_02_04_05_06_08_09_0A,
                    72'h01_02_03_05_06_07_09_0A_0B,
                    72'h05_06_07_09_0A_0B_0D_0E_0F};

        reset    = 1'b1;
        start    = 1'b0;
        cfg_w    = '0;
        cfg_h    = '0;
        cfg_pool = 1'b0;
        in_pixel = '0;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_win_en", win_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chkw("rst_win", win, '0);
        chkw("rst_win_k2", win2, '0);

        // Bad configs: width below K, then height above MAX_H
        for (int k = 0; k < 2; k++) begin
            cfg_w    = (k == 0) ? 5'd2 : 5'd4;
            cfg_h    = (k == 0) ? 5'd4 : 5'd29;
            cfg_pool = 1'b0;
            start    = 1'b1;
            tick();
            start = 1'b0;
            chk1($sformatf("badcfg%0d_err", k), err, 1'b1);
            chk1($sformatf("badcfg%0d_busy", k), busy, 1'b0);
            chk1($sformatf("badcfg%0d_in_ready", k), in_ready, 1'b0);
            tick();
            chk1($sformatf("badcfg%0d_err_one_cycle", k), err, 1'b0);
            chk1($sformatf("badcfg%0d_still_idle", k), busy, 1'b0);
        end

        for (int i = 0; i < 4; i++) run_job(jobs[i], i);

        // K=2 build, pixels 1..9, then reset while windows are streaming
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        cfg_w    = 5'd3;
        cfg_h    = 5'd3;
        cfg_pool = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk1("k2_busy_fill", busy2, 1'b1);
        feed(9, 1, 1'b0, fc);
        chki("k2_fill_cycles", fc, 9);
        tick();
        chk1("k2_win_en0", win_en2, 1'b1);
        chkw("k2_win0", win2, 72'h01_02_04_05_00_00_00_00_00);
        tick();
        chk1("k2_win_en1", win_en2, 1'b1);
        chkw("k2_win1", win2, 72'h02_03_05_06_00_00_00_00_00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("k2_rst_win_en", win_en2, 1'b0);
        chk1("k2_rst_busy", busy2, 1'b0);
        chk1("k2_rst_done", done2, 1'b0);
        chk1("k2_rst_in_ready", in_ready2, 1'b0);
        chk1("k2_rst_err", err2, 1'b0);
        tick();
        chk1("k2_no_done_later", done2, 1'b0);
        chk1("k2_idle_later", busy2, 1'b0);
        chk1("k2_no_win_later", win_en2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
